// File: rtl/id_exe_reg_pkg.sv
// Shared ARM pipeline definitions: field widths, the decoded control
// bundle carried from ID to EXE, and the all-zero bubble used for squashed
// or invalid slots.
package arm_pipe_pkg;

  localparam int EXE_CMD_W  = 4;
  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;

  typedef struct packed {
    logic                 WB_EN;
    logic                 MEM_R_EN;
    logic                 MEM_W_EN;
    logic                 B;
    logic                 S;
    logic [EXE_CMD_W-1:0] EXE_CMD;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    WB_EN:    1'b0,
    MEM_R_EN: 1'b0,
    MEM_W_EN: 1'b0,
    B:        1'b0,
    S:        1'b0,
    EXE_CMD:  4'b0000
  };

  // An instruction that is not real must never write, branch or set flags.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    ctrl_t r;
    if (valid) begin
      r = c;
    end else begin
      r = CTRL_BUBBLE;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// ID -> EXE pipeline bus. The decode stage (master) drives the *_in
// fields and observes the registered copies; the pipeline register
// (slave) consumes the *_in fields and drives the registered copies.
interface id_exe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);
  import arm_pipe_pkg::*;

  // decode-side fields
  logic                  valid_in;
  logic [DATA_W-1:0]     PC_in;
  logic                  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
  logic [EXE_CMD_W-1:0]  EXE_CMD_in;
  logic [DATA_W-1:0]     Val_Rn_in, Val_Rm_in;
  logic                  imm_in;
  logic [SHIFT_OP_W-1:0] Shift_operand_in;
  logic [IMM24_W-1:0]    Signed_imm_24_in;
  logic [REG_W-1:0]      Dest_in, src1_in, src2_in;
  logic                  C_in;

  // execute-side registered copies
  logic                  valid_out;
  logic [DATA_W-1:0]     PC;
  logic                  WB_EN, MEM_R_EN, MEM_W_EN, B, S;
  logic [EXE_CMD_W-1:0]  EXE_CMD;
  logic [DATA_W-1:0]     Val_Rn, Val_Rm;
  logic                  imm;
  logic [SHIFT_OP_W-1:0] Shift_operand;
  logic [IMM24_W-1:0]    Signed_imm_24;
  logic [REG_W-1:0]      Dest, src1, src2;
  logic                  C_out;

  modport master (
    output valid_in, PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
           EXE_CMD_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
           Signed_imm_24_in, Dest_in, src1_in, src2_in, C_in,
    input  valid_out, PC, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
           Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24,
           Dest, src1, src2, C_out
  );

  modport slave (
    input  valid_in, PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
           EXE_CMD_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
           Signed_imm_24_in, Dest_in, src1_in, src2_in, C_in,
    output valid_out, PC, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
           Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24,
           Dest, src1, src2, C_out
  );
endinterface

// File: rtl/id_exe_reg_sat_counter.sv
// Saturating event counter: counts up by one on each edge with inc=1,
// sticks at all-ones, clears asynchronously on rst=0.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // count register, held once it reaches all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (stall) and flush (squash).
// Priority per edge: rst, flush, freeze, normal load. Control bits of an
// invalid slot are loaded as a bubble; data fields are still captured.
// Optional build macro ID_EXE_PERF_CNT_EN adds stall/flush/bubble counters.
module id_exe_reg
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
`ifdef ID_EXE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  id_exe_reg_if.slave      bus
);

  ctrl_t                 ctrl_in_s;
  ctrl_t                 ctrl_r;
  logic                  valid_r;
  logic [DATA_W-1:0]     pc_r, val_rn_r, val_rm_r;
  logic                  imm_r, c_r;
  logic [SHIFT_OP_W-1:0] shift_op_r;
  logic [IMM24_W-1:0]    imm24_r;
  logic [REG_W-1:0]      dest_r, src1_r, src2_r;

  // assemble the decoded control bundle, bubbled when the slot is not real
  always_comb begin
    ctrl_in_s = gate_ctrl('{WB_EN:    bus.WB_EN_in,
                            MEM_R_EN: bus.MEM_R_EN_in,
                            MEM_W_EN: bus.MEM_W_EN_in,
                            B:        bus.B_in,
                            S:        bus.S_in,
                            EXE_CMD:  bus.EXE_CMD_in}, bus.valid_in);
  end

  // pipeline register: reset/flush clear everything, freeze holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      ctrl_r     <= CTRL_BUBBLE;
      valid_r    <= 1'b0;
      pc_r       <= {DATA_W{1'b0}};
      val_rn_r   <= {DATA_W{1'b0}};
      val_rm_r   <= {DATA_W{1'b0}};
      imm_r      <= 1'b0;
      shift_op_r <= {SHIFT_OP_W{1'b0}};
      imm24_r    <= {IMM24_W{1'b0}};
      dest_r     <= {REG_W{1'b0}};
      src1_r     <= {REG_W{1'b0}};
      src2_r     <= {REG_W{1'b0}};
      c_r        <= 1'b0;
    end else if (!freeze) begin
      ctrl_r     <= ctrl_in_s;
      valid_r    <= bus.valid_in;
      pc_r       <= bus.PC_in;
      val_rn_r   <= bus.Val_Rn_in;
      val_rm_r   <= bus.Val_Rm_in;
      imm_r      <= bus.imm_in;
      shift_op_r <= bus.Shift_operand_in;
      imm24_r    <= bus.Signed_imm_24_in;
      dest_r     <= bus.Dest_in;
      src1_r     <= bus.src1_in;
      src2_r     <= bus.src2_in;
      c_r        <= bus.C_in;
    end
  end

  assign bus.valid_out     = valid_r;
  assign bus.PC            = pc_r;
  assign bus.WB_EN         = ctrl_r.WB_EN;
  assign bus.MEM_R_EN      = ctrl_r.MEM_R_EN;
  assign bus.MEM_W_EN      = ctrl_r.MEM_W_EN;
  assign bus.B             = ctrl_r.B;
  assign bus.S             = ctrl_r.S;
  assign bus.EXE_CMD       = ctrl_r.EXE_CMD;
  assign bus.Val_Rn        = val_rn_r;
  assign bus.Val_Rm        = val_rm_r;
  assign bus.imm           = imm_r;
  assign bus.Shift_operand = shift_op_r;
  assign bus.Signed_imm_24 = imm24_r;
  assign bus.Dest          = dest_r;
  assign bus.src1          = src1_r;
  assign bus.src2          = src2_r;
  assign bus.C_out         = c_r;

`ifdef ID_EXE_PERF_CNT_EN
  logic stall_inc_s, flush_inc_s, bubble_inc_s;

  // classify this edge; the three events are mutually exclusive
  always_comb begin
    flush_inc_s  = flush;
    stall_inc_s  = freeze & ~flush;
    bubble_inc_s = ~freeze & ~flush & ~bus.valid_in;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_inc_s), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_inc_s), .cnt(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(bubble_inc_s), .cnt(bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: reset, load, freeze, flush-over-freeze,
// invalid-slot gating, full field capture, async reset during a stall,
// and (with ID_EXE_PERF_CNT_EN) the performance counters.
module tb_id_exe_reg;
  import arm_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  id_exe_reg_if #(.DATA_W(32), .REG_W(4)) bus ();

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, bubble_cnt;
  logic        rst4 = 1'b0;
  logic        freeze4 = 1'b0;
  logic [3:0]  stall_cnt4, flush_cnt4, bubble_cnt4;
  id_exe_reg_if #(.DATA_W(32), .REG_W(4)) bus4 ();
`endif

  id_exe_reg #(.DATA_W(32), .REG_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
`ifdef ID_EXE_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt),
`endif
    .bus(bus.slave)
  );

`ifdef ID_EXE_PERF_CNT_EN
  id_exe_reg #(.DATA_W(32), .REG_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .freeze(freeze4), .flush(1'b0),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .bubble_cnt(bubble_cnt4),
    .bus(bus4.slave)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ins();
    bus.valid_in = 1'b0;         bus.PC_in = 32'h0;
    bus.WB_EN_in = 1'b0;         bus.MEM_R_EN_in = 1'b0;
    bus.MEM_W_EN_in = 1'b0;      bus.B_in = 1'b0;
    bus.S_in = 1'b0;             bus.EXE_CMD_in = 4'h0;
    bus.Val_Rn_in = 32'h0;       bus.Val_Rm_in = 32'h0;
    bus.imm_in = 1'b0;           bus.Shift_operand_in = 12'h0;
    bus.Signed_imm_24_in = 24'h0;
    bus.Dest_in = 4'h0;          bus.src1_in = 4'h0;
    bus.src2_in = 4'h0;          bus.C_in = 1'b0;
  endtask

  // one rising edge, then land on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef ID_EXE_PERF_CNT_EN
    bus4.valid_in = 1'b1;        bus4.PC_in = 32'h0;
    bus4.WB_EN_in = 1'b0;        bus4.MEM_R_EN_in = 1'b0;
    bus4.MEM_W_EN_in = 1'b0;     bus4.B_in = 1'b0;
    bus4.S_in = 1'b0;            bus4.EXE_CMD_in = 4'h0;
    bus4.Val_Rn_in = 32'h0;      bus4.Val_Rm_in = 32'h0;
    bus4.imm_in = 1'b0;          bus4.Shift_operand_in = 12'h0;
    bus4.Signed_imm_24_in = 24'h0;
    bus4.Dest_in = 4'h0;         bus4.src1_in = 4'h0;
    bus4.src2_in = 4'h0;         bus4.C_in = 1'b0;
`endif
    // reset held with nonzero inputs while the clock toggles
    clear_ins();
    bus.valid_in = 1'b1; bus.PC_in = 32'hABCD; bus.WB_EN_in = 1'b1;
    bus.EXE_CMD_in = 4'h9; bus.Val_Rm_in = 32'h1234; bus.C_in = 1'b1;
    repeat (3) step();
    chk("rst_pc", bus.PC, 64'h0);
    chk("rst_wb", bus.WB_EN, 64'h0);
    chk("rst_cmd", bus.EXE_CMD, 64'h0);
    chk("rst_valid", bus.valid_out, 64'h0);
    chk("rst_rm", bus.Val_Rm, 64'h0);
    chk("rst_c", bus.C_out, 64'h0);

    // release, then ADD appears after one edge
    rst = 1'b1;
`ifdef ID_EXE_PERF_CNT_EN
    rst4 = 1'b1;
`endif
    clear_ins();
    bus.valid_in = 1'b1; bus.EXE_CMD_in = 4'b0010; bus.WB_EN_in = 1'b1;
    bus.Val_Rn_in = 32'h5; bus.Dest_in = 4'h3;
    step();
    chk("add_cmd", bus.EXE_CMD, 64'h2);
    chk("add_wb", bus.WB_EN, 64'h1);
    chk("add_rn", bus.Val_Rn, 64'h5);
    chk("add_dest", bus.Dest, 64'h3);
    chk("add_valid", bus.valid_out, 64'h1);
    chk("add_memr", bus.MEM_R_EN, 64'h0);

    // load A, then freeze three edges while inputs change to B
    bus.PC_in = 32'h10; bus.Val_Rn_in = 32'hA1;
    step();
    chk("a_pc", bus.PC, 64'h10);
    freeze = 1'b1; bus.PC_in = 32'h14; bus.Val_Rn_in = 32'hB2; bus.valid_in = 1'b0;
    repeat (3) step();
    chk("frz_pc", bus.PC, 64'h10);
    chk("frz_rn", bus.Val_Rn, 64'hA1);
    chk("frz_valid", bus.valid_out, 64'h1);
    freeze = 1'b0; bus.valid_in = 1'b1;
    step();
    chk("b_pc", bus.PC, 64'h14);
    chk("b_rn", bus.Val_Rn, 64'hB2);

    // flush and freeze together: flush wins
    freeze = 1'b1; flush = 1'b1; bus.MEM_W_EN_in = 1'b1; bus.PC_in = 32'h20;
    step();
    chk("fl_memw", bus.MEM_W_EN, 64'h0);
    chk("fl_cmd", bus.EXE_CMD, 64'h0);
    chk("fl_valid", bus.valid_out, 64'h0);
    chk("fl_pc", bus.PC, 64'h0);
    chk("fl_rn", bus.Val_Rn, 64'h0);

    // invalid slot: control bubbled, data still captured
    freeze = 1'b0; flush = 1'b0;
    clear_ins();
    bus.valid_in = 1'b0; bus.WB_EN_in = 1'b1; bus.S_in = 1'b1;
    bus.EXE_CMD_in = 4'h5; bus.Val_Rm_in = 32'hDEADBEEF;
    step();
    chk("inv_wb", bus.WB_EN, 64'h0);
    chk("inv_s", bus.S, 64'h0);
    chk("inv_cmd", bus.EXE_CMD, 64'h0);
    chk("inv_valid", bus.valid_out, 64'h0);
    chk("inv_rm", bus.Val_Rm, 64'hDEADBEEF);

    // every field captured on a valid load
    clear_ins();
    bus.valid_in = 1'b1; bus.PC_in = 32'h0000_0100; bus.MEM_R_EN_in = 1'b1;
    bus.B_in = 1'b1; bus.S_in = 1'b1; bus.EXE_CMD_in = 4'hC;
    bus.imm_in = 1'b1; bus.Shift_operand_in = 12'hA5F;
    bus.Signed_imm_24_in = 24'h80_0001; bus.src1_in = 4'h7;
    bus.src2_in = 4'hE; bus.Dest_in = 4'hF; bus.C_in = 1'b1;
    step();
    chk("all_memr", bus.MEM_R_EN, 64'h1);
    chk("all_b", bus.B, 64'h1);
    chk("all_s", bus.S, 64'h1);
    chk("all_cmd", bus.EXE_CMD, 64'hC);
    chk("all_imm", bus.imm, 64'h1);
    chk("all_shift", bus.Shift_operand, 64'hA5F);
    chk("all_imm24", bus.Signed_imm_24, 64'h800001);
    chk("all_src1", bus.src1, 64'h7);
    chk("all_src2", bus.src2, 64'hE);
    chk("all_dest", bus.Dest, 64'hF);
    chk("all_c", bus.C_out, 64'h1);
    chk("all_pc", bus.PC, 64'h100);

    // async reset during a stall, between edges
    freeze = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", bus.PC, 64'h0);
    chk("arst_valid", bus.valid_out, 64'h0);
    chk("arst_cmd", bus.EXE_CMD, 64'h0);
    chk("arst_c", bus.C_out, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;

`ifdef ID_EXE_PERF_CNT_EN
    // counters: fresh reset, then 5 stalls, 2 flushes (1 with freeze), 3 bubbles
    rst = 1'b0;
    #1 rst = 1'b1;
    chk("cnt_rst_stall", stall_cnt, 64'h0);
    clear_ins();
    bus.valid_in = 1'b1;
    freeze = 1'b1;
    repeat (5) step();
    flush = 1'b1;
    step();
    freeze = 1'b0;
    step();
    flush = 1'b0; bus.valid_in = 1'b0;
    repeat (3) step();
    bus.valid_in = 1'b1;
    step();
    chk("cnt_stall", stall_cnt, 64'd5);
    chk("cnt_flush", flush_cnt, 64'd2);
    chk("cnt_bubble", bubble_cnt, 64'd3);

    // 4-bit stall counter saturates after 20 stalls
    freeze4 = 1'b1;
    repeat (14) step();
    chk("cnt4_14", stall_cnt4, 64'hE);
    repeat (6) step();
    chk("cnt4_sat", stall_cnt4, 64'hF);
    chk("cnt4_bubble", bubble_cnt4, 64'h0);
    freeze4 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the ARM decode stage and the execute stage.
- Captures decoded control bits, operand values, immediates, register indices, PC and the status-register carry at each clock edge.
- Supports freeze (stall) and flush (branch-taken squash). Flushed or invalid slots reach EXE as zero-control bubbles.

Parameters:
- DATA_W, 32, width of PC, Val_Rn and Val_Rm.
- REG_W, 4, width of register indices (Dest, src1, src2).
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- freeze  in  1  hold all registered state this cycle.
- flush  in  1  squash this cycle's capture; load a bubble.
- valid_in  in  1  decode slot holds a real instruction.
- PC_in  in  DATA_W  PC of the decoded instruction.
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in  in  1 each  decoded control bits.
- EXE_CMD_in  in  4  ALU command.
- Val_Rn_in, Val_Rm_in  in  DATA_W  register-file operands.
- imm_in  in  1  immediate operand flag.
- Shift_operand_in  in  12  shifter operand field.
- Signed_imm_24_in  in  24  branch offset.
- Dest_in, src1_in, src2_in  in  REG_W  register indices.
- C_in  in  1  carry flag from the status register.
- Same names without the _in suffix  out  same widths  registered copies, plus C_out.
- valid_out  out  1  EXE slot holds a real instruction.

Behaviour:
- Reset: while rst=0, every output is 0, regardless of clk. Release is asynchronous; the first capture happens on the first rising edge with rst=1.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N and stay stable until the next load.
- Priority per edge: rst, then flush, then freeze, then normal load.
- flush=1:
  - Clear control outputs: WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD=0, valid_out=0.
  - Clear data fields to 0 for determinism.
  - flush overrides a simultaneous freeze.
- freeze=1, flush=0: all outputs hold their previous values, including valid_out.
- Normal load: capture all inputs, with valid_out=valid_in.
- Gating on valid_in=0: when valid_in=0 on a load, capture control bits as 0 regardless of their input values. Data fields are still captured.
- No internal state machine beyond the register. Inter-edge outputs depend only on register state; no combinational path from inputs to outputs.
- Reset mid-stall or mid-flush: reset wins immediately. The freeze/flush history is not retained.

Optional Feature:
- Macro: ID_EXE_PERF_CNT_EN.
- When defined, add three outputs:
  - stall_cnt (CNT_W): edges with freeze=1 and flush=0.
  - flush_cnt (CNT_W): edges with flush=1.
  - bubble_cnt (CNT_W): normal loads with valid_in=0.
- Counter rules:
  - Each counter saturates at all-ones and does not wrap.
  - All counters clear on reset.
  - Each counter increments at most once per edge.
- When undefined: the ports and logic are absent, and pipeline behaviour is identical.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - constants EXE_CMD_W=4, SHIFT_OP_W=12, IMM24_W=24;
  - packed struct ctrl_t {WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD};
  - constant CTRL_BUBBLE (all zero).
- One natural sub-module: sat_counter (CNT_W, inc, clk, rst), instantiated three times under the macro.

Test Plan:
- Reset: hold rst=0 with nonzero inputs and toggling clk → all outputs 0; release rst, present ADD (EXE_CMD=4'b0010, WB_EN=1, Val_Rn=32'h5, Dest=4'h3, valid_in=1) → outputs match after one edge.
- Freeze: load instruction A (PC=32'h10), then freeze=1 for 3 edges while the inputs change to B (PC=32'h14) → outputs stay A; on release B appears after one edge.
- Flush vs freeze: freeze=1 and flush=1 on the same edge with MEM_W_EN_in=1 → MEM_W_EN=0, EXE_CMD=0, valid_out=0, PC=0.
- Invalid slot: valid_in=0, WB_EN_in=1, S_in=1, Val_Rm_in=32'hDEADBEEF → WB_EN=0, S=0, valid_out=0, Val_Rm=32'hDEADBEEF.
- Async reset mid-freeze: during freeze, drive rst low between clock edges → outputs go to 0 without waiting for a clock edge.
- Perf counters (ID_EXE_PERF_CNT_EN): 5 freeze edges, 2 flush edges (1 with freeze), 3 invalid loads → stall_cnt=5, flush_cnt=2, bubble_cnt=3; preload at CNT_W=4 with 20 stalls → stall_cnt=4'hF.
